mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (IF) and the memory
// stage (DM). One transaction is in flight at a time, data wins over fetch,
// and a fixed memory latency is counted before completing the requester.
// A halt request sequences one dump strobe once the port is idle, then the
// arbiter parks in HALTED until reset.
module mem_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  input  logic        halt,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_dump,
  output logic        halted
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_DM = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_wr;
  logic        r_halt_pend;

  logic w_dm_req;
  logic w_halt_req;
  logic w_idle;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_dump;
  logic w_last;
  logic w_if_done;
  logic w_dm_done;
  logic w_halted;

  // Grant decode: data beats halt beats fetch, only while idle and out of reset
  always_comb begin
    w_dm_req   = dm_read | dm_write;
    w_halt_req = halt | r_halt_pend;
    w_idle     = (r_state == S_IDLE) & ~rst;
    w_grant_dm = w_idle & w_dm_req;
    w_dump     = w_idle & ~w_dm_req & w_halt_req;
    w_grant_if = w_idle & ~w_dm_req & ~w_halt_req & if_req;
    w_last     = (r_cnt == LAT);
    w_if_done  = (r_state == S_BUSY_IF) & w_last & ~rst;
    w_dm_done  = (r_state == S_BUSY_DM) & w_last & ~rst;
    w_halted   = (r_state == S_HALTED);
  end

  // Memory port and requester handshakes; the issue cycle bypasses the latches
  always_comb begin
    mem_enable = w_grant_dm | w_grant_if;
    mem_dump   = w_dump;
    halted     = w_halted;
    if (w_grant_dm) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_wr    = dm_write;
    end else if (w_grant_if) begin
      mem_addr  = if_addr;
      mem_wdata = r_wdata;
      mem_wr    = 1'b0;
    end else begin
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      mem_wr    = r_wr;
    end
    if_done  = w_if_done;
    dm_done  = w_dm_done;
    if_rdata = w_if_done ? mem_rdata : 16'h0000;
    dm_rdata = (w_dm_done & ~r_wr) ? mem_rdata : 16'h0000;
    if_stall = if_req & ~w_if_done & ~w_halted & ~rst;
    dm_stall = w_dm_req & ~w_dm_done & ~w_halted & ~rst;
  end

  // Sequencer: grant, latch the transaction, count latency, park on halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_wr        <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_addr      <= dm_addr;
            r_wdata     <= dm_wdata;
            r_wr        <= dm_write;
            r_cnt       <= 4'd1;
            r_halt_pend <= r_halt_pend | halt;
            r_state     <= S_BUSY_DM;
          end else if (w_dump) begin
            r_halt_pend <= 1'b0;
            r_state     <= S_HALTED;
          end else if (w_grant_if) begin
            r_addr  <= if_addr;
            r_wr    <= 1'b0;
            r_cnt   <= 4'd1;
            r_state <= S_BUSY_IF;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY_IF, S_BUSY_DM: begin
          // a halt seen mid-transaction is remembered for the next idle cycle
          r_halt_pend <= r_halt_pend | halt;
          if (w_last) begin
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on a LATENCY=2 instance, a
// back-to-back scenario on a LATENCY=1 instance, and randomized traffic
// checked against a transaction-level timing model.
module tb_mem_arbiter;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, dm_read, dm_write, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_enable, mem_wr, mem_dump, halted;

  logic        rst1, if_req1, dm_read1, dm_write1, halt1;
  logic [15:0] if_addr1, dm_addr1, dm_wdata1, mem_rdata1;
  logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
  logic        if_done1, if_stall1, dm_done1, dm_stall1, mem_enable1, mem_wr1, mem_dump1, halted1;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.LATENCY(LAT0)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall), .halt(halt),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_dump(mem_dump), .halted(halted)
  );

  mem_arbiter #(.LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1), .if_stall(if_stall1),
    .dm_read(dm_read1), .dm_write(dm_write1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_done(dm_done1), .dm_stall(dm_stall1), .halt(halt1),
    .mem_enable(mem_enable1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_dump(mem_dump1), .halted(halted1)
  );

  wire [7:0] obs  = {mem_enable, mem_wr, mem_dump, halted, if_done, if_stall, dm_done, dm_stall};
  wire [7:0] obs1 = {mem_enable1, mem_wr1, mem_dump1, halted1, if_done1, if_stall1, dm_done1, dm_stall1};

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Memory model for the LATENCY=2 instance: data valid exactly LAT0 cycles after issue
  logic [15:0] env_mem [0:65535];
  int          env_age  = 0;
  logic [15:0] env_addr = 16'h0000;
  logic        env_wr   = 1'b0;

  always @(posedge clk) begin
    if (mem_enable) begin
      env_age  <= 1;
      env_addr <= mem_addr;
      env_wr   <= mem_wr;
      if (mem_wr) env_mem[mem_addr] <= mem_wdata;
      mem_rdata <= (LAT0 == 1 && !mem_wr) ? env_mem[mem_addr] : 16'($urandom);
    end else begin
      if (env_age != 0) env_age <= env_age + 1;
      mem_rdata <= (env_age != 0 && env_age + 1 == LAT0 && !env_wr) ? env_mem[env_addr] : 16'($urandom);
    end
  end

  // Reference memory contents as seen by the requesters
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] ref_lookup(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 16'h0000; dm_read = 1'b0; dm_write = 1'b0;
    dm_addr = 16'h0000; dm_wdata = 16'h0000; halt = 1'b0;
    if_req1 = 1'b0; if_addr1 = 16'h0000; dm_read1 = 1'b0; dm_write1 = 1'b0;
    dm_addr1 = 16'h0000; dm_wdata1 = 16'h0000; halt1 = 1'b0; mem_rdata1 = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL reset_flags got=%b want=%b", obs, 8'h00); end
    total++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h want=0", {mem_addr, mem_wdata}); end
    total++;
    if ({if_rdata, dm_rdata} !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", {if_rdata, dm_rdata}); end
    total++;
    if ({obs1, mem_addr1, mem_wdata1, if_rdata1, dm_rdata1} !== 72'h0) begin
      bad++; $display("FAIL reset_lat1 got=%h want=0", {obs1, mem_addr1, mem_wdata1, if_rdata1, dm_rdata1});
    end
    next_cycle();
  endtask

  task automatic test_fetch();
    logic [7:0] exp [4];
    exp = '{8'h84, 8'h04, 8'h08, 8'h00};
    if_req = 1'b1; if_addr = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) if_req = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL fetch_flags c=%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 0) begin
        total++;
        if (mem_addr !== 16'h0010) begin bad++; $display("FAIL fetch_addr got=%h want=0010", mem_addr); end
      end
      if (c == 1) begin
        total++;
        if (if_rdata !== 16'h0000) begin bad++; $display("FAIL fetch_rdata_early got=%h want=0000", if_rdata); end
      end
      if (c == 2) begin
        total++;
        if (if_rdata !== 16'hA5A5) begin bad++; $display("FAIL fetch_rdata got=%h want=a5a5", if_rdata); end
      end
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp [7];
    exp = '{8'h85, 8'h05, 8'h06, 8'h84, 8'h04, 8'h08, 8'h00};
    if_req = 1'b1; if_addr = 16'h0020; dm_read = 1'b1; dm_addr = 16'h0100;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) dm_read = 1'b0;
      if (c == 6) if_req = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL prio_flags c=%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 0 || c == 3) begin
        total++;
        if (mem_addr !== (c == 0 ? 16'h0100 : 16'h0020)) begin bad++; $display("FAIL prio_addr c=%0d got=%h", c, mem_addr); end
      end
      if (c == 2) begin
        total++;
        if (dm_rdata !== ref_lookup(16'h0100)) begin bad++; $display("FAIL prio_dm_rdata got=%h want=%h", dm_rdata, ref_lookup(16'h0100)); end
      end
      if (c == 5) begin
        total++;
        if (if_rdata !== ref_lookup(16'h0020)) begin bad++; $display("FAIL prio_if_rdata got=%h want=%h", if_rdata, ref_lookup(16'h0020)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_write();
    logic [7:0] exp [4];
    exp = '{8'hC1, 8'h41, 8'h42, 8'h40};
    dm_write = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    ref_mem[16'h0200] = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dm_write = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL write_flags c=%0d got=%b want=%b", c, obs, exp[c]); end
      if (c < 3) begin
        total++;
        if ({mem_addr, mem_wdata} !== 32'h0200_1234) begin bad++; $display("FAIL write_bus c=%0d got=%h want=02001234", c, {mem_addr, mem_wdata}); end
      end
      if (c == 2) begin
        total++;
        if (dm_rdata !== 16'h0000) begin bad++; $display("FAIL write_rdata got=%h want=0000", dm_rdata); end
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    logic [7:0] exp [8];
    exp = '{8'h84, 8'h04, 8'h08, 8'h20, 8'h10, 8'h10, 8'h10, 8'h10};
    if_req = 1'b1; if_addr = 16'h0030;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) halt = 1'b1;
      if (c == 3) if_req = 1'b0;
      if (c == 5) begin if_req = 1'b1; if_addr = 16'h0031; dm_read = 1'b1; dm_addr = 16'h0101; end
      if (c == 7) clear_inputs();
      @(negedge clk);
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL halt_flags c=%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 2) begin
        total++;
        if (if_rdata !== ref_lookup(16'h0030)) begin bad++; $display("FAIL halt_if_rdata got=%h want=%h", if_rdata, ref_lookup(16'h0030)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [7];
    exp = '{8'h81, 8'h00, 8'h00, 8'h84, 8'h04, 8'h08, 8'h00};
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    dm_read = 1'b1; dm_addr = 16'h0100;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin rst = 1'b1; dm_read = 1'b0; end
      if (c == 2) rst = 1'b0;
      if (c == 3) begin if_req = 1'b1; if_addr = 16'h0040; end
      if (c == 6) if_req = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== exp[c]) begin bad++; $display("FAIL rstmid_flags c=%0d got=%b want=%b", c, obs, exp[c]); end
      if (c == 2) begin
        total++;
        if ({mem_addr, mem_wdata, dm_rdata} !== 48'h0) begin bad++; $display("FAIL rstmid_bus got=%h want=0", {mem_addr, mem_wdata, dm_rdata}); end
      end
      if (c == 3) begin
        total++;
        if (mem_addr !== 16'h0040) begin bad++; $display("FAIL rstmid_addr got=%h want=0040", mem_addr); end
      end
      if (c == 5) begin
        total++;
        if (if_rdata !== ref_lookup(16'h0040)) begin bad++; $display("FAIL rstmid_rdata got=%h want=%h", if_rdata, ref_lookup(16'h0040)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp [5];
    logic [15:0] rd  [5];
    logic [15:0] ex_rd [5];
    exp   = '{8'h81, 8'h02, 8'h81, 8'h02, 8'h00};
    rd    = '{16'hBEEF, 16'h0F0F, 16'h7777, 16'hC3C3, 16'h1111};
    ex_rd = '{16'h0000, 16'h0F0F, 16'h0000, 16'hC3C3, 16'h0000};
    dm_read1 = 1'b1; dm_addr1 = 16'h0300;
    for (int c = 0; c < 5; c++) begin
      mem_rdata1 = rd[c];
      if (c == 2) dm_addr1 = 16'h0304;
      if (c == 4) dm_read1 = 1'b0;
      @(negedge clk);
      total++;
      if (obs1 !== exp[c]) begin bad++; $display("FAIL b2b_flags c=%0d got=%b want=%b", c, obs1, exp[c]); end
      total++;
      if (dm_rdata1 !== ex_rd[c]) begin bad++; $display("FAIL b2b_rdata c=%0d got=%h want=%h", c, dm_rdata1, ex_rd[c]); end
      if (c == 0 || c == 2) begin
        total++;
        if (mem_addr1 !== (c == 0 ? 16'h0300 : 16'h0304)) begin bad++; $display("FAIL b2b_addr c=%0d got=%h", c, mem_addr1); end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int          issue_c = -100;
    int          owner   = 0;
    logic [15:0] exp_data = 16'h0000;
    logic        e_en, e_ifd, e_dmd, dm_req;
    logic [6:0]  e_flags, got_flags;
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 16'h0400 | 16'($urandom_range(0, 15));
      end
      if (!(dm_read || dm_write) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin dm_read = 1'b1; dm_write = 1'b0; end
          2:       begin dm_read = 1'b0; dm_write = 1'b1; end
          default: begin dm_read = 1'b1; dm_write = 1'b1; end
        endcase
        dm_addr  = 16'h0400 | 16'($urandom_range(0, 15));
        dm_wdata = 16'($urandom);
      end
      @(negedge clk);
      dm_req = dm_read | dm_write;
      e_en = 1'b0; e_ifd = 1'b0; e_dmd = 1'b0;
      if (c <= issue_c + LAT0) begin
        if (c == issue_c + LAT0) begin
          e_ifd = (owner == 1);
          e_dmd = (owner == 2);
        end
      end else if (dm_req) begin
        e_en = 1'b1; issue_c = c; owner = 2;
        if (dm_write) begin
          ref_mem[dm_addr] = dm_wdata;
          exp_data = 16'h0000;
        end else begin
          exp_data = ref_lookup(dm_addr);
        end
        total++;
        if ({mem_addr, mem_wr} !== {dm_addr, dm_write} || (dm_write && mem_wdata !== dm_wdata)) begin
          bad++; $display("FAIL rnd_dm_issue c=%0d got=%h/%b/%h want=%h/%b/%h", c, mem_addr, mem_wr, mem_wdata, dm_addr, dm_write, dm_wdata);
        end
      end else if (if_req) begin
        e_en = 1'b1; issue_c = c; owner = 1;
        exp_data = ref_lookup(if_addr);
        total++;
        if ({mem_addr, mem_wr} !== {if_addr, 1'b0}) begin
          bad++; $display("FAIL rnd_if_issue c=%0d got=%h/%b want=%h/0", c, mem_addr, mem_wr, if_addr);
        end
      end
      e_flags   = {e_en, 1'b0, 1'b0, e_ifd, if_req & ~e_ifd, e_dmd, dm_req & ~e_dmd};
      got_flags = {mem_enable, mem_dump, halted, if_done, if_stall, dm_done, dm_stall};
      total++;
      if (got_flags !== e_flags) begin bad++; $display("FAIL rnd_flags c=%0d got=%b want=%b", c, got_flags, e_flags); end
      total++;
      if ({if_rdata, dm_rdata} !== {(e_ifd ? exp_data : 16'h0000), (e_dmd ? exp_data : 16'h0000)}) begin
        bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h/%h", c, if_rdata, dm_rdata,
                        (e_ifd ? exp_data : 16'h0000), (e_dmd ? exp_data : 16'h0000));
      end
      next_cycle();
      if (e_ifd) if_req = 1'b0;
      if (e_dmd) begin dm_read = 1'b0; dm_write = 1'b0; end
    end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) env_mem[i] = init_word(16'(i));
    env_mem[16'h0010] = 16'hA5A5;
    ref_mem[16'h0010] = 16'hA5A5;
    rst = 1'b1; rst1 = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
